// File: rtl/johnson_counter_param.sv
// ---------------------------------------------------------------------------
// johnson_counter_param
//   Parametrised twisted-ring (Johnson) / ring counter used as a sequencer or
//   phase generator. Runtime selection of Johnson or ring sequence, shift
//   direction, step enable and synchronous parallel load. Illegal states are
//   flagged and, when AUTOCORRECT=1, forced home on the next enabled edge.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   en_i        in   step enable
//   dir_i       in   0 = up (shift toward MSB), 1 = down (shift toward LSB)
//   mode_i      in   0 = Johnson (2*WIDTH states), 1 = ring (WIDTH states)
//   load_i      in   synchronous parallel load strobe (highest priority)
//   load_val_i  in   value loaded verbatim when load_i=1
//   count_o     out  registered counter state
//   index_o     out  combinational position of count_o in its sequence
//   illegal_o   out  combinational: count_o not legal for mode_i
//   wrap_o      out  registered one-cycle pulse: a step just landed on home
//
// Handshake: none. All inputs are sampled on every rising edge; there is no
// valid/ready pair, the counter simply acts on whatever is presented.
// ---------------------------------------------------------------------------
module johnson_counter_param #(
  parameter int WIDTH       = 4,
  parameter bit AUTOCORRECT = 1'b1,
  localparam int IW         = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic [IW-1:0]    index_o,
  output logic             illegal_o,
  output logic             wrap_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [IW:0] TWO_W = (IW + 1)'(2 * WIDTH);

  logic [WIDTH-1:0] count_q, count_d;
  logic             mode_q;
  logic             wrap_q, wrap_d;

  logic [CW-1:0]    ones;
  logic [CW-1:0]    edges;
  logic [IW-1:0]    ring_pos;
  logic [IW:0]      john_idx;
  logic [WIDTH-1:0] home;
  logic [WIDTH-1:0] step_up;
  logic [WIDTH-1:0] step_dn;
  logic [WIDTH-1:0] step_nxt;

  // Home state follows the live mode input: Johnson = all zeros, ring = 0..01.
  assign home = mode_i ? WIDTH'(1) : '0;

  // Population count, count of adjacent-bit transitions and position of the
  // highest set bit (the only set bit for a legal ring state).
  always_comb begin
    ones     = '0;
    edges    = '0;
    ring_pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (count_q[i]) begin
        ones     = ones + CW'(1);
        ring_pos = IW'(i);
      end
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (count_q[i] != count_q[i+1]) edges = edges + CW'(1);
    end
  end

  // Johnson sequence fills with ones from the LSB, then drains them from the
  // LSB; the MSB tells which half of the sequence we are in.
  assign john_idx  = count_q[WIDTH-1] ? (TWO_W - (IW + 1)'(ones)) : (IW + 1)'(ones);

  assign illegal_o = mode_i ? (ones != CW'(1)) : (edges > CW'(1));

  always_comb begin
    index_o = '0;
    if (!illegal_o) index_o = mode_i ? ring_pos : john_idx[IW-1:0];
  end

  // Feedback bit is inverted for Johnson, straight for ring.
  assign step_up  = {count_q[WIDTH-2:0], mode_i ? count_q[WIDTH-1] : ~count_q[WIDTH-1]};
  assign step_dn  = {mode_i ? count_q[0] : ~count_q[0], count_q[WIDTH-1:1]};
  assign step_nxt = dir_i ? step_dn : step_up;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load_i) begin
      count_d = load_val_i;
    end else if (mode_i != mode_q) begin
      // Mode switch re-homes the counter whether or not it is enabled.
      count_d = home;
    end else if (en_i && illegal_o && AUTOCORRECT) begin
      count_d = home;
    end else if (en_i) begin
      count_d = step_nxt;
      wrap_d  = (step_nxt == home);
    end
  end

  // Reset value depends on the mode input so the counter comes out of reset
  // already sitting on the home state of the selected sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= mode_i ? WIDTH'(1) : '0;
      mode_q  <= mode_i;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      mode_q  <= mode_i;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_johnson_counter_param.sv
module tb_johnson_counter_param;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, dir = 1'b0, mode = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;

  always #5 clk = ~clk;

  // W=4, autocorrect on (main DUT)
  logic [3:0] cnt;   logic [2:0] idx;   logic ill, wrap;
  // W=4, autocorrect off
  logic [3:0] cnt_n; logic [2:0] idx_n; logic ill_n, wrap_n;
  // W=5, autocorrect on
  logic [4:0] cnt5;  logic [3:0] idx5;  logic ill5, wrap5;

  johnson_counter_param #(.WIDTH(4), .AUTOCORRECT(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .dir_i(dir), .mode_i(mode), .load_i(load),
    .load_val_i(load_val), .count_o(cnt), .index_o(idx), .illegal_o(ill), .wrap_o(wrap));

  johnson_counter_param #(.WIDTH(4), .AUTOCORRECT(1'b0)) u_nac (
    .clk(clk), .rst_n(rst_n), .en_i(en), .dir_i(dir), .mode_i(mode), .load_i(load),
    .load_val_i(load_val), .count_o(cnt_n), .index_o(idx_n), .illegal_o(ill_n), .wrap_o(wrap_n));

  johnson_counter_param #(.WIDTH(5), .AUTOCORRECT(1'b1)) u_w5 (
    .clk(clk), .rst_n(rst_n), .en_i(en), .dir_i(dir), .mode_i(mode), .load_i(load),
    .load_val_i({1'b0, load_val}), .count_o(cnt5), .index_o(idx5), .illegal_o(ill5), .wrap_o(wrap5));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic m);
    rst_n = 1'b0; mode = m; en = 1'b0; load = 1'b0; dir = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Legal sequences listed by index; everything else is done by lookup.
  function automatic logic [3:0] seq_val(input int k, input logic m);
    logic [3:0] v;
    if (m)          v = 4'(1 << k);
    else if (k < 4) v = 4'((1 << k) - 1);
    else            v = 4'hF ^ 4'((1 << (k - 4)) - 1);
    return v;
  endfunction

  function automatic int seq_pos(input logic [3:0] v, input logic m);
    int p;
    p = -1;
    for (int k = 0; k < (m ? 4 : 8); k++) if (seq_val(k, m) == v) p = k;
    return p;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic       en, dir, mode, load;
    logic [3:0] lv;
    logic [3:0] ecnt;
    logic [2:0] eidx;
    logic       eill, ewrap;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic e, d, m, l, input logic [3:0] lv, c,
                              input logic [2:0] i, input logic il, w);
    vec_t v;
    v.en = e; v.dir = d; v.mode = m; v.load = l; v.lv = lv;
    v.ecnt = c; v.eidx = i; v.eill = il; v.ewrap = w;
    return v;
  endfunction

  logic [3:0] m_cnt;
  logic       m_mq, e_wrap;
  int         p, np, nn, ep;
  int         wrap_cycles[$];

  initial begin
    //            en dir mode load lv    cnt  idx ill wrap
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'h1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'h3, 2, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'h7, 3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'hF, 4, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'hE, 5, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'hC, 6, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'h8, 7, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'h0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0)); // hold, no wrap
    tbl.push_back(mk(1, 1, 0, 0, 4'h0, 4'h8, 7, 0, 0)); // down from home
    tbl.push_back(mk(1, 1, 0, 0, 4'h0, 4'hC, 6, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'h8, 7, 0, 0)); // reverse, no skip
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'h0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 1, 4'h7, 4'h7, 0, 1, 0)); // load beats en+mode
    tbl.push_back(mk(1, 0, 1, 0, 4'h0, 4'h1, 0, 0, 0)); // autocorrect to ring home
    tbl.push_back(mk(1, 0, 1, 0, 4'h0, 4'h2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 4'h0, 4'h4, 2, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 4'h0, 4'h8, 3, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 4'h0, 4'h1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0)); // mode change with en=0
    tbl.push_back(mk(1, 0, 0, 1, 4'h5, 4'h5, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0)); // autocorrect: no wrap
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'h1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 4'h0, 4'h0, 0, 0, 1)); // down from index 1 wraps
    tbl.push_back(mk(0, 0, 0, 1, 4'h7, 4'h7, 3, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 4'h0, 4'h3, 2, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 4'h0, 4'h1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 4'h0, 4'h0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 4'h0, 4'h8, 7, 0, 0));

    // ---- reset state ----
    do_reset(1'b0);
    chk("reset.cnt",  32'(cnt),  32'h0);
    chk("reset.idx",  32'(idx),  32'h0);
    chk("reset.ill",  32'(ill),  32'h0);
    chk("reset.wrap", 32'(wrap), 32'h0);

    // ---- table-driven vectors ----
    foreach (tbl[i]) begin
      en = tbl[i].en; dir = tbl[i].dir; mode = tbl[i].mode;
      load = tbl[i].load; load_val = tbl[i].lv;
      cycle();
      chk($sformatf("vec%0d.cnt", i),  32'(cnt),  32'(tbl[i].ecnt));
      chk($sformatf("vec%0d.idx", i),  32'(idx),  32'(tbl[i].eidx));
      chk($sformatf("vec%0d.ill", i),  32'(ill),  32'(tbl[i].eill));
      chk($sformatf("vec%0d.wrap", i), 32'(wrap), 32'(tbl[i].ewrap));
    end

    // ---- reset in ring mode lands on ring home ----
    do_reset(1'b1);
    chk("reset_ring.cnt", 32'(cnt), 32'h1);

    // ---- mode 0->1 mid-count with en=0 ----
    do_reset(1'b0);
    en = 1'b1; dir = 1'b0; mode = 1'b0; load = 1'b0;
    cycle(); cycle(); cycle();
    chk("mid.cnt", 32'(cnt), 32'h7);
    en = 1'b0; mode = 1'b1;
    cycle();
    chk("modesw.cnt",  32'(cnt),  32'h1);
    chk("modesw.wrap", 32'(wrap), 32'h0);

    // ---- autocorrect disabled: illegal state keeps stepping ----
    do_reset(1'b0);
    en = 1'b0; load = 1'b1; load_val = 4'h5;
    cycle();
    chk("nac.load.cnt", 32'(cnt_n), 32'h5);
    chk("nac.load.ill", 32'(ill_n), 32'h1);
    chk("nac.load.idx", 32'(idx_n), 32'h0);
    load = 1'b0; en = 1'b1; dir = 1'b0;
    exp_q.push_back(32'hB); exp_q.push_back(32'h6);
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk($sformatf("nac.step%0d.cnt", k), 32'(cnt_n), exp_q.pop_front());
      chk($sformatf("nac.step%0d.ill", k), 32'(ill_n), 32'h1);
    end
    dir = 1'b1;
    cycle();
    chk("nac.down.cnt", 32'(cnt_n), 32'hB);
    chk("nac.down.ill", 32'(ill_n), 32'h1);

    // ---- W=5 Johnson free run: wrap period 10 ----
    do_reset(1'b0);
    en = 1'b1; dir = 1'b0; mode = 1'b0; load = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      if (wrap5) wrap_cycles.push_back(k);
    end
    chk("w5.nwraps", 32'(wrap_cycles.size()), 32'd3);
    for (int k = 0; k < wrap_cycles.size(); k++)
      chk($sformatf("w5.wrap%0d", k), 32'(wrap_cycles[k]), 32'(10 * (k + 1)));

    // ---- async reset mid-count ----
    cycle(); cycle(); cycle();
    chk("w5.precnt", 32'(cnt5), 32'h07);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async.cnt5", 32'(cnt5), 32'h00);
    chk("async.cnt",  32'(cnt),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- randomized run against the reference model ----
    do_reset(1'b0);
    m_cnt = 4'h0; m_mq = 1'b0;
    for (int n = 0; n < 400; n++) begin
      en       = ($urandom_range(3) != 0);
      dir      = 1'($urandom_range(1));
      if ($urandom_range(9) == 0) mode = ~mode;
      load     = ($urandom_range(7) == 0);
      load_val = 4'($urandom_range(15));

      nn = mode ? 4 : 8;
      p  = seq_pos(m_cnt, mode);
      e_wrap = 1'b0;
      if (load) m_cnt = load_val;
      else if (mode != m_mq) m_cnt = seq_val(0, mode);
      else if (en && p < 0) m_cnt = seq_val(0, mode);
      else if (en) begin
        np = dir ? (p + nn - 1) % nn : (p + 1) % nn;
        m_cnt = seq_val(np, mode);
        e_wrap = (np == 0);
      end
      m_mq = mode;
      ep = seq_pos(m_cnt, mode);

      cycle();
      chk($sformatf("rnd%0d.cnt", n),  32'(cnt),  32'(m_cnt));
      chk($sformatf("rnd%0d.idx", n),  32'(idx),  (ep < 0) ? 32'h0 : 32'(ep));
      chk($sformatf("rnd%0d.ill", n),  32'(ill),  32'(ep < 0));
      chk($sformatf("rnd%0d.wrap", n), 32'(wrap), 32'(e_wrap));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
